// File: rtl/aging_pattern_gen.sv
// Aging / burn-in RGB pattern generator.
// Takes the registered {vsync, hsync, de} bus from the timing generator.
// Produces a 24-bit test pattern that lines up with a copy of that bus
// delayed by two clocks. The pattern can be selected by hand, or the block
// can step through the patterns every N frames. A new pattern always takes
// effect on a vsync rising edge, so every frame is drawn with one pattern.
module aging_pattern_gen #(
    parameter int NUM_PAT   = 8,
    parameter int CHK_SHIFT = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  sync_i,
    input  logic [11:0] h_size,
    input  logic        auto_en,
    input  logic [2:0]  pattern_sel,
    input  logic [7:0]  frames_per_pat,
    output logic [2:0]  sync_o,
    output logic [23:0] rgb_o,
    output logic [2:0]  pattern_idx_o,
    output logic        frame_tick_o
);

    typedef enum logic [2:0] {
        PAT_BLACK = 3'd0,
        PAT_WHITE = 3'd1,
        PAT_RED   = 3'd2,
        PAT_GREEN = 3'd3,
        PAT_BLUE  = 3'd4,
        PAT_BARS  = 3'd5,
        PAT_CHK   = 3'd6,
        PAT_RAMP  = 3'd7
    } pattern_e;

    localparam logic [2:0] LAST_PAT = 3'(NUM_PAT - 1);

    // Edge detection
    logic        vs_prev_r;
    logic        de_prev_r;
    logic        vs_rise_s;
    logic        de_fall_s;

    // Stage 1 counters and pipeline registers
    logic [2:0]  sync_d1_r;
    logic [11:0] x_cnt_r;
    logic [10:0] y_cnt_r;
    logic [11:0] bar_pos_r;
    logic [2:0]  bar_idx_r;
    logic [7:0]  x_d1_r;
    logic        chk_d1_r;
    logic [2:0]  bar_d1_r;
    logic [11:0] bar_w_s;

    // Pattern selection state
    pattern_e    pattern_r;
    pattern_e    pattern_nxt_s;
    logic [7:0]  frame_cnt_r;
    logic [7:0]  frame_cnt_nxt_s;
    logic [7:0]  eff_fpp_s;
    logic        frame_tick_r;

    // Stage 2 outputs
    logic [2:0]  sync_o_r;
    logic [23:0] rgb_r;

    assign vs_rise_s = sync_i[2] & ~vs_prev_r;
    assign de_fall_s = ~sync_i[0] & de_prev_r;
    assign bar_w_s   = ((h_size >> 3'd3) == 12'd0) ? 12'd1 : (h_size >> 3'd3);
    assign eff_fpp_s = (frames_per_pat == 8'd0) ? 8'd1 : frames_per_pat;

    // Colour for one active pixel, given the pattern and the stage-1 position data.
    function automatic logic [23:0] colour_f(
        input pattern_e   pat,
        input logic [7:0] x_lo,
        input logic       chk,
        input logic [2:0] bar
    );
        logic [23:0] c;
        case (pat)
            PAT_BLACK: c = 24'h000000;
            PAT_WHITE: c = 24'hFFFFFF;
            PAT_RED:   c = 24'hFF0000;
            PAT_GREEN: c = 24'h00FF00;
            PAT_BLUE:  c = 24'h0000FF;
            PAT_BARS: begin
                case (bar)
                    3'd0:    c = 24'hFFFFFF;
                    3'd1:    c = 24'hFFFF00;
                    3'd2:    c = 24'h00FFFF;
                    3'd3:    c = 24'h00FF00;
                    3'd4:    c = 24'hFF00FF;
                    3'd5:    c = 24'hFF0000;
                    3'd6:    c = 24'h0000FF;
                    3'd7:    c = 24'h000000;
                    default: c = 24'h000000;
                endcase
            end
            PAT_CHK:  c = chk ? 24'hFFFFFF : 24'h000000;
            PAT_RAMP: c = {x_lo, x_lo, x_lo};
            default:  c = 24'h000000;
        endcase
        return c;
    endfunction

    // Stage 1: edge history, the pixel/line/bar counters, and the first pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev_r <= 1'b0;
            de_prev_r <= 1'b0;
            sync_d1_r <= 3'd0;
            x_cnt_r   <= 12'd0;
            y_cnt_r   <= 11'd0;
            bar_pos_r <= 12'd0;
            bar_idx_r <= 3'd0;
            x_d1_r    <= 8'd0;
            chk_d1_r  <= 1'b0;
            bar_d1_r  <= 3'd0;
        end else begin
            vs_prev_r <= sync_i[2];
            de_prev_r <= sync_i[0];
            sync_d1_r <= sync_i;
            x_d1_r    <= x_cnt_r[7:0];
            chk_d1_r  <= x_cnt_r[CHK_SHIFT] ^ y_cnt_r[CHK_SHIFT];
            bar_d1_r  <= bar_idx_r;
            if (sync_i[0]) begin
                x_cnt_r <= x_cnt_r + 12'd1;
                if (bar_pos_r == (bar_w_s - 12'd1)) begin
                    bar_pos_r <= 12'd0;
                    // Stop at the last bar so that lines wider than h_size stay black.
                    if (bar_idx_r != 3'd7) begin
                        bar_idx_r <= bar_idx_r + 3'd1;
                    end else begin
                        bar_idx_r <= bar_idx_r;
                    end
                end else begin
                    bar_pos_r <= bar_pos_r + 12'd1;
                end
            end else begin
                x_cnt_r   <= 12'd0;
                bar_pos_r <= 12'd0;
                bar_idx_r <= 3'd0;
            end
            // If a frame start and a line end fall in the same cycle, the frame start wins.
            if (vs_rise_s) begin
                y_cnt_r <= 11'd0;
            end else if (de_fall_s) begin
                y_cnt_r <= y_cnt_r + 11'd1;
            end else begin
                y_cnt_r <= y_cnt_r;
            end
        end
    end

    // Pattern selection next state. It moves only on a vsync rising edge.
    always_comb begin
        pattern_nxt_s   = pattern_r;
        frame_cnt_nxt_s = frame_cnt_r;
        if (vs_rise_s) begin
            if (!auto_en) begin
                pattern_nxt_s   = pattern_e'(pattern_sel);
                frame_cnt_nxt_s = 8'd0;
            end else if (frame_cnt_r >= (eff_fpp_s - 8'd1)) begin
                frame_cnt_nxt_s = 8'd0;
                if (pattern_r == pattern_e'(LAST_PAT)) begin
                    pattern_nxt_s = PAT_BLACK;
                end else begin
                    pattern_nxt_s = pattern_e'(pattern_r + 3'd1);
                end
            end else begin
                frame_cnt_nxt_s = frame_cnt_r + 8'd1;
            end
        end else begin
            pattern_nxt_s   = pattern_r;
            frame_cnt_nxt_s = frame_cnt_r;
        end
    end

    // Pattern selection state register and the registered frame tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_r    <= PAT_BLACK;
            frame_cnt_r  <= 8'd0;
            frame_tick_r <= 1'b0;
        end else begin
            pattern_r    <= pattern_nxt_s;
            frame_cnt_r  <= frame_cnt_nxt_s;
            frame_tick_r <= vs_rise_s;
        end
    end

    // Stage 2: the delayed sync bus and the colour, which is blanked outside active video.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_o_r <= 3'd0;
            rgb_r    <= 24'd0;
        end else begin
            sync_o_r <= sync_d1_r;
            rgb_r    <= sync_d1_r[0] ? colour_f(pattern_r, x_d1_r, chk_d1_r, bar_d1_r)
                                     : 24'h000000;
        end
    end

    assign sync_o        = sync_o_r;
    assign rgb_o         = rgb_r;
    assign pattern_idx_o = pattern_r;
    assign frame_tick_o  = frame_tick_r;

endmodule

// File: tb/tb_aging_pattern_gen.sv
// Self-checking bench for aging_pattern_gen.
// A scoreboard queue holds the expected {sync, rgb} for each driven cycle,
// and each entry is checked when it leaves the two-stage pipeline.
// The bench keeps its own model of the pattern selection and predicts
// pattern_idx_o and frame_tick_o one cycle after each drive.
module tb_aging_pattern_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  sync_i;
    logic [11:0] h_size;
    logic        auto_en;
    logic [2:0]  pattern_sel;
    logic [7:0]  frames_per_pat;
    logic [2:0]  sync_o;
    logic [23:0] rgb_o;
    logic [2:0]  pattern_idx_o;
    logic        frame_tick_o;

    int n_chk  = 0;
    int n_pass = 0;

    logic [26:0] sb_q[$];

    // Bench-side model state
    logic m_vs_prev;
    logic m_de_prev;
    int   m_pat;
    int   m_fcnt;
    int   m_x;
    int   m_y;

    aging_pattern_gen #(.NUM_PAT(8), .CHK_SHIFT(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sync_i         (sync_i),
        .h_size         (h_size),
        .auto_en        (auto_en),
        .pattern_sel    (pattern_sel),
        .frames_per_pat (frames_per_pat),
        .sync_o         (sync_o),
        .rgb_o          (rgb_o),
        .pattern_idx_o  (pattern_idx_o),
        .frame_tick_o   (frame_tick_o)
    );

    // Pixel clock
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] exp_rgb(input int pat, input int x, input int y);
        int bw;
        int b;
        logic [23:0] bars [8];
        logic [7:0]  g;
        bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
        bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
        case (pat)
            0: return 24'h000000;
            1: return 24'hFFFFFF;
            2: return 24'hFF0000;
            3: return 24'h00FF00;
            4: return 24'h0000FF;
            5: begin
                bw = int'(h_size) / 8;
                if (bw == 0) bw = 1;
                b = x / bw;
                if (b > 7) b = 7;
                return bars[b];
            end
            6: return ((((x / 32) ^ (y / 32)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
            default: begin
                g = 8'(x % 256);
                return {g, g, g};
            end
        endcase
    endfunction

    task automatic model_reset();
        m_vs_prev = 1'b0;
        m_de_prev = 1'b0;
        m_pat     = 0;
        m_fcnt    = 0;
        m_x       = 0;
        m_y       = 0;
    endtask

    // Drive one clock of sync, predict the results, and check whatever is due.
    task automatic cyc(input logic [2:0] s);
        logic        vs_rise;
        logic        de_fall;
        int          eff;
        logic [23:0] e_rgb;
        logic [26:0] e;
        sync_i  = s;
        vs_rise = s[2] & ~m_vs_prev;
        de_fall = ~s[0] & m_de_prev;
        if (vs_rise) begin
            eff = (frames_per_pat == 8'd0) ? 1 : int'(frames_per_pat);
            if (!auto_en) begin
                m_pat  = int'(pattern_sel);
                m_fcnt = 0;
            end else if (m_fcnt + 1 >= eff) begin
                m_fcnt = 0;
                m_pat  = (m_pat + 1) % 8;
            end else begin
                m_fcnt = m_fcnt + 1;
            end
        end
        e_rgb = s[0] ? exp_rgb(m_pat, m_x, m_y) : 24'h000000;
        sb_q.push_back({s, e_rgb});
        m_x = s[0] ? m_x + 1 : 0;
        if (vs_rise) m_y = 0;
        else if (de_fall) m_y = m_y + 1;
        m_vs_prev = s[2];
        m_de_prev = s[0];
        @(posedge clk);
        #1;
        check_val("frame_tick", 32'(frame_tick_o), 32'(vs_rise));
        check_val("pattern_idx", 32'(pattern_idx_o), 32'(m_pat));
        if (sb_q.size() == 2) begin
            e = sb_q.pop_front();
            check_val("sync_o", 32'(sync_o), 32'(e[26:24]));
            check_val("rgb_o", 32'(rgb_o), 32'(e[23:0]));
        end
    endtask

    // One frame: vsync pulse, back porch, then lines of active pixels with hsync blanking.
    task automatic frame(input int lines, input int pix, input int chg_pix, input logic [2:0] chg_val);
        cyc(3'b100);
        cyc(3'b100);
        cyc(3'b000);
        cyc(3'b000);
        for (int l = 0; l < lines; l++) begin
            for (int p = 0; p < pix; p++) begin
                if (l == 0 && p == chg_pix) pattern_sel = chg_val;
                cyc(3'b001);
            end
            cyc(3'b010);
            cyc(3'b010);
            cyc(3'b000);
            cyc(3'b000);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        sync_i         = 3'b111;
        h_size         = 12'd64;
        auto_en        = 1'b0;
        pattern_sel    = 3'd0;
        frames_per_pat = 8'd3;
        model_reset();

        // Reset values while sync_i is fully asserted
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_sync_o", 32'(sync_o), 32'd0);
        check_val("rst_rgb_o", 32'(rgb_o), 32'd0);
        check_val("rst_idx", 32'(pattern_idx_o), 32'd0);
        check_val("rst_tick", 32'(frame_tick_o), 32'd0);
        sync_i = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cyc(3'b000);

        // Colour bars, 8-pixel bars across a 64-pixel line
        pattern_sel = 3'd5;
        frame(1, 64, -1, 3'd0);
        // Narrow line: bar width clamps to 1 and the bar index saturates at 7
        h_size = 12'd4;
        frame(1, 12, -1, 3'd0);
        h_size = 12'd64;

        // Checkerboard over 33 lines, then the grey ramp out past pixel 256
        pattern_sel = 3'd6;
        frame(33, 64, -1, 3'd0);
        pattern_sel = 3'd7;
        frame(1, 260, -1, 3'd0);

        // Manual change in mid-line: red for this frame, blue from the next
        pattern_sel = 3'd2;
        frame(1, 16, 5, 3'd4);
        frame(1, 16, -1, 3'd0);

        // Auto cycling every 3 frames, starting at pattern 0
        pattern_sel = 3'd0;
        frame(1, 4, -1, 3'd0);
        auto_en        = 1'b1;
        frames_per_pat = 8'd3;
        repeat (24) frame(2, 8, -1, 3'd0);
        check_val("auto_wrap", 32'(pattern_idx_o), 32'd0);

        // frames_per_pat = 0 advances on every frame
        frames_per_pat = 8'd0;
        repeat (4) frame(1, 8, -1, 3'd0);
        cyc(3'b100);
        cyc(3'b100);
        cyc(3'b000);
        repeat (4) cyc(3'b001);
        check_val("pre_reset_idx", 32'(pattern_idx_o), 32'd5);

        // Asynchronous reset in the middle of a line; no clock edge in between
        #1;
        rst_n = 1'b0;
        #1;
        check_val("arst_sync_o", 32'(sync_o), 32'd0);
        check_val("arst_rgb_o", 32'(rgb_o), 32'd0);
        check_val("arst_idx", 32'(pattern_idx_o), 32'd0);
        check_val("arst_tick", 32'(frame_tick_o), 32'd0);
        sb_q.delete();
        model_reset();
        sync_i = 3'b000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("post_rst_idx", 32'(pattern_idx_o), 32'd0);
        frames_per_pat = 8'd3;
        repeat (4) frame(1, 8, -1, 3'd0);
        check_val("post_rst_auto", 32'(pattern_idx_o), 32'd1);

        cyc(3'b000);
        cyc(3'b000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/aging_pattern_gen.md
Name: aging_pattern_gen

Overview:
- Downstream stage of the timing generator. Consumes its registered 3-bit sync bus {vsync, hsync, de}.
- Produces a 24-bit RGB aging/burn-in test pattern aligned with a delayed copy of the sync bus.
- The pattern is selected manually, or auto-cycled every N frames. Pattern changes take effect only at frame boundaries (vsync rising edge).
- Output feeds the colour-space-conversion stage.

Parameters:
- NUM_PAT, 8: number of patterns; index width is 3 bits.
- CHK_SHIFT, 5: checkerboard square size is 2^CHK_SHIFT pixels/lines.

Ports:
- clk  input  1  pixel clock
- rst_n  input  1  reset; asynchronous, active-low
- sync_i  input  3  {vsync, hsync, de} from the timing generator, active-high
- h_size  input  12  active pixels per line (colour-bar width source)
- auto_en  input  1  1 = auto-cycle patterns, 0 = manual select
- pattern_sel  input  3  manual pattern index
- frames_per_pat  input  8  frames per pattern in auto mode; 0 is treated as 1
- sync_o  output  3  sync_i delayed 2 cycles
- rgb_o  output  24  {R[7:0], G[7:0], B[7:0]}, aligned with sync_o
- pattern_idx_o  output  3  pattern currently being displayed
- frame_tick_o  output  1  one-cycle pulse on each detected vsync rising edge

Behaviour:
- Reset: everything is cleared asynchronously on rst_n low. Internal registers: x/y counters, bar counters, frame counter, pipeline regs. Outputs: sync_o=0, rgb_o=0, pattern_idx_o=0, frame_tick_o=0. Release is synchronous to clk. A reset mid-frame restarts from pattern 0 with all counters cleared.
- Edge detect: vs_rise = vsync & ~vsync_prev; de_fall = ~de & de_prev. The prev registers reset to 0, so vsync=1 in the first cycle after reset counts as a rise.
- Stage 1 (per clk):
  - sync_d1 <= sync_i; x_d1 <= x_cnt; y_d1 <= y_cnt; bar_d1 <= bar_idx.
  - x_cnt <= de ? x_cnt+1 : 0. This is the 12-bit index of the current active pixel within the line.
  - bar_w = h_size>>3, forced to 1 if 0.
  - bar_pos/bar_idx cleared when de=0. When de=1: bar_pos increments; on bar_pos==bar_w-1, bar_pos<=0 and bar_idx increments, saturating at 7.
  - y_cnt (11 bits): cleared on vs_rise, else incremented on de_fall. vs_rise has priority if both occur.
- Stage 2: sync_o <= sync_d1; rgb_o <= de_d1 ? colour(pattern, x_d1, y_d1, bar_d1) : 24'h000000. Total latency is 2 cycles.
- Patterns:
  - 0 black 000000
  - 1 white FFFFFF
  - 2 red FF0000
  - 3 green 00FF00
  - 4 blue 0000FF
  - 5 colour bars by bar_idx 0..7: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000
  - 6 checkerboard: FFFFFF if x[CHK_SHIFT]^y[CHK_SHIFT], else 000000
  - 7 horizontal grey ramp {g,g,g} with g = x[7:0]
- Pattern FSM: updates only on the vs_rise cycle, so the pattern is constant for the whole frame.
  - Manual (auto_en=0): pattern_idx <= pattern_sel; frame_cnt <= 0.
  - Auto (auto_en=1): if frame_cnt >= eff_fpp-1, then frame_cnt <= 0 and pattern_idx <= pattern_idx+1 (7 wraps to 0); else frame_cnt+1. Here eff_fpp = max(frames_per_pat,1).
  - Switching auto_en, pattern_sel or frames_per_pat mid-frame has no effect until the next vs_rise.
  - Auto cycling continues from the current pattern_idx.
- pattern_idx_o is the registered pattern_idx. The new value is visible the cycle after vs_rise, ahead of the first active pixel because of the vsync/de spacing.
- frame_tick_o is registered: high for the one cycle after vs_rise is detected.
- Widths: all counters are unsigned and wrap at their width. No overflow checks.

Test Plan:
- Reset/latency: hold rst_n=0, drive sync_i=3'b111 → all outputs 0. Release; drive de high at cycle T → sync_o[0] rises at T+2, first pixel's rgb_o valid at T+2.
- Colour bars: h_size=64, manual pattern 5, 64-pixel de line → rgb_o is FFFFFF for pixels 0–7, FFFF00 for 8–15, …, 000000 for 56–63. rgb_o=0 outside de.
- Checker/ramp, CHK_SHIFT=5:
  - Pattern 6, line 0: pixels 0–31 are 000000, 32–63 are FFFFFF. Line 32 is inverted.
  - Pattern 7: pixel 200 gives C8C8C8; pixel 256 gives 000000.
- Auto-cycle: auto_en=1, frames_per_pat=3, start at 0 → pattern_idx_o steps 0→1 after 3 vsync rises, …, 7→0 after 24. frame_tick_o pulses once per frame.
- Mid-frame change: manual, change pattern_sel 2→4 mid-line → rgb_o stays FF0000 until the frame ends, then 0000FF after the next vsync rise. frames_per_pat=0 with auto → pattern advances every frame.
- Async reset mid-frame in auto mode at pattern 5 → outputs go 0 immediately without a clock. After release, pattern_idx_o=0 and frame_cnt restarts.
